// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline stages: channel count and the
// signed ReLU / max helpers used by the pooling datapath.
package cnn_pkg;

    localparam int NCH   = 4;
    // Helpers work on a wide signed type. Callers sign-extend into it and
    // truncate back out, so one definition serves any data width up to 64.
    localparam int CALCW = 64;

    typedef logic signed [CALCW-1:0] calc_t;

    // Clamp negative values to zero.
    function automatic calc_t relu(input calc_t d);
        return (d < 0) ? '0 : d;
    endfunction

    // Signed maximum; on a tie either operand is the same value.
    function automatic calc_t smax(input calc_t a, input calc_t b);
        return (a < b) ? b : a;
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Half-width line buffer holding the horizontal pair maxima of an even row,
// all channels packed into one word. Storage is never reset: every entry is
// written on the even row before the odd row reads it.
module pool_linebuf #(
    parameter int DEPTH = 13,
    parameter int WIDTH = 128,
    parameter int AW    = 4
) (
    input  logic             iClk,
    input  logic             iWe,
    input  logic [AW-1:0]    iAddr,
    input  logic [WIDTH-1:0] iWdata,
    output logic [WIDTH-1:0] oRdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Single write port.
    always_ff @(posedge iClk) begin
        if (iWe) begin
            mem_q[iAddr] <= iWdata;
        end
    end

    // Asynchronous read on the same index as the write.
    assign oRdata = mem_q[iAddr];

endmodule

// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2 stride-2 max pooling on four parallel conv streams.
// Beats arrive in raster order; one pooled value per channel is emitted the
// cycle after the beat that completes each 2x2 block.
module relu_maxpool2x2
    import cnn_pkg::*;
#(
    parameter int ACCW = 32,
    parameter int FW   = 26,
    parameter int FH   = 26
) (
    input  logic                   iClk,
    input  logic                   iRsn,
    input  logic [3:0]             iValid4,
    input  logic signed [ACCW-1:0] iData0,
    input  logic signed [ACCW-1:0] iData1,
    input  logic signed [ACCW-1:0] iData2,
    input  logic signed [ACCW-1:0] iData3,
    output logic [3:0]             oValid4,
    output logic signed [ACCW-1:0] oData0,
    output logic signed [ACCW-1:0] oData1,
    output logic signed [ACCW-1:0] oData2,
    output logic signed [ACCW-1:0] oData3,
    output logic                   oMapDone,
    output logic                   oErr
);

    localparam int CW   = $clog2(FW);
    localparam int RW   = $clog2(FH);
    localparam int LBD  = FW / 2;
    localparam int LAW  = (LBD > 1) ? $clog2(LBD) : 1;
    // Trailing odd column/row lies outside the pooled region.
    localparam int COLS = 2 * (FW / 2);
    localparam int ROWS = 2 * (FH / 2);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic signed [ACCW-1:0] din    [NCH];
    logic signed [ACCW-1:0] relu_v [NCH];
    logic signed [ACCW-1:0] pm_v   [NCH];
    logic signed [ACCW-1:0] pool_v [NCH];
    logic signed [ACCW-1:0] lb_rd  [NCH];
    logic signed [ACCW-1:0] pair_q [NCH];
    logic signed [ACCW-1:0] pair_d [NCH];
    logic signed [ACCW-1:0] data_q [NCH];
    logic signed [ACCW-1:0] data_d [NCH];

    logic [NCH*ACCW-1:0] lb_wdata;
    logic [NCH*ACCW-1:0] lb_rdata;
    logic [LAW-1:0]      lb_addr;

    logic beat;
    logic in_region;
    logic fire_out;
    logic lb_we;
    logic map_last;

    assign din[0] = iData0;
    assign din[1] = iData1;
    assign din[2] = iData2;
    assign din[3] = iData3;

    assign beat      = (iValid4 == 4'hF);
    assign in_region = (int'(col_q) < COLS) && (int'(row_q) < ROWS);
    assign fire_out  = beat && in_region && col_q[0] && row_q[0];
    assign lb_we     = beat && in_region && col_q[0] && !row_q[0];
    assign map_last  = beat && (col_q == CW'(FW - 1)) && (row_q == RW'(FH - 1));
    assign lb_addr   = LAW'(col_q >> 1);

    // Per-channel datapath: ReLU, horizontal pair max, then vertical max
    // against the line-buffer entry for the same column pair.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign relu_v[gi] = ACCW'(relu(calc_t'(din[gi])));
            assign pm_v[gi]   = ACCW'(smax(calc_t'(pair_q[gi]), calc_t'(relu_v[gi])));
            assign pool_v[gi] = ACCW'(smax(calc_t'(pm_v[gi]), calc_t'(lb_rd[gi])));
            assign lb_wdata[gi*ACCW +: ACCW] = pm_v[gi];
            assign lb_rd[gi]  = lb_rdata[gi*ACCW +: ACCW];
        end
    endgenerate

    pool_linebuf #(
        .DEPTH (LBD),
        .WIDTH (NCH * ACCW),
        .AW    (LAW)
    ) u_linebuf (
        .iClk   (iClk),
        .iWe    (lb_we),
        .iAddr  (lb_addr),
        .iWdata (lb_wdata),
        .oRdata (lb_rdata)
    );

    // Raster counters, output strobes and the sticky protocol-error flag.
    // Malformed valid patterns are flagged but otherwise ignored.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = fire_out;
        done_d  = map_last;
        err_d   = err_q | ((iValid4 != 4'h0) && !beat);
        if (beat) begin
            if (col_q == CW'(FW - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(FH - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Pair register captures even columns; output data holds until the next pooled value.
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            pair_d[ch] = pair_q[ch];
            data_d[ch] = data_q[ch];
            if (beat && in_region && !col_q[0]) begin
                pair_d[ch] = relu_v[ch];
            end
            if (fire_out) begin
                data_d[ch] = pool_v[ch];
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                pair_q[ch] <= '0;
                data_q[ch] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int ch = 0; ch < NCH; ch++) begin
                pair_q[ch] <= pair_d[ch];
                data_q[ch] <= data_d[ch];
            end
        end
    end

    assign oValid4  = {4{valid_q}};
    assign oData0   = data_q[0];
    assign oData1   = data_q[1];
    assign oData2   = data_q[2];
    assign oData3   = data_q[3];
    assign oMapDone = done_q;
    assign oErr     = err_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Bench for relu_maxpool2x2: a 4x4 and a 5x5 instance driven with directed
// and random maps, checked beat by beat against a frame-level reference that
// stores every ReLU'd pixel and takes the max over each completed 2x2 block.
module tb_relu_maxpool2x2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [3:0]         v4  [2];
    logic signed [31:0] din [2][4];
    logic [3:0]         ov  [2];
    logic signed [31:0] od  [2][4];
    logic               md  [2];
    logic               er  [2];

    relu_maxpool2x2 #(.ACCW(32), .FW(4), .FH(4)) dut4 (
        .iClk(clk), .iRsn(rst_n), .iValid4(v4[0]),
        .iData0(din[0][0]), .iData1(din[0][1]), .iData2(din[0][2]), .iData3(din[0][3]),
        .oValid4(ov[0]),
        .oData0(od[0][0]), .oData1(od[0][1]), .oData2(od[0][2]), .oData3(od[0][3]),
        .oMapDone(md[0]), .oErr(er[0])
    );

    relu_maxpool2x2 #(.ACCW(32), .FW(5), .FH(5)) dut5 (
        .iClk(clk), .iRsn(rst_n), .iValid4(v4[1]),
        .iData0(din[1][0]), .iData1(din[1][1]), .iData2(din[1][2]), .iData3(din[1][3]),
        .oValid4(ov[1]),
        .oData0(od[1][0]), .oData1(od[1][1]), .oData2(od[1][2]), .oData3(od[1][3]),
        .oMapDone(md[1]), .oErr(er[1])
    );

    int total = 0;
    int bad   = 0;
    int fw  [2] = '{4, 5};
    int pos [2] = '{0, 0};
    int img [2][5][5][4];
    bit err_exp [2] = '{1'b0, 1'b0};

    function automatic int relu_m(input int x);
        return (x < 0) ? 0 : x;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_quiet(input int s);
        chk($sformatf("idle_valid u%0d", s), 64'(ov[s]), 64'd0);
        chk($sformatf("idle_done u%0d", s), 64'(md[s]), 64'd0);
        chk($sformatf("idle_err u%0d", s), 64'(er[s]), 64'(err_exp[s]));
    endtask

    // One beat on unit s, preceded by 'gap' idle cycles, then check the
    // registered outputs that follow it.
    task automatic send(input int s, input int a0, input int a1, input int a2, input int a3,
                        input int gap);
        int r, c, pn, e;
        bit ev;
        int vals [4];
        vals = '{a0, a1, a2, a3};
        repeat (gap) begin
            @(posedge clk); #1;
            chk_quiet(s);
        end
        r = pos[s] / fw[s];
        c = pos[s] % fw[s];
        v4[s] = 4'hF;
        for (int k = 0; k < 4; k++) begin
            din[s][k] = vals[k];
            img[s][r][c][k] = relu_m(vals[k]);
        end
        @(posedge clk); #1;
        v4[s] = 4'h0;
        pn = 2 * (fw[s] / 2);
        ev = (r % 2 == 1) && (c % 2 == 1) && (r < pn) && (c < pn);
        chk($sformatf("valid u%0d r%0d c%0d", s, r, c), 64'(ov[s]), ev ? 64'hF : 64'h0);
        if (ev) begin
            for (int k = 0; k < 4; k++) begin
                e = max4(img[s][r-1][c-1][k], img[s][r-1][c][k], img[s][r][c-1][k], img[s][r][c][k]);
                $display("u%0d out r%0d c%0d ch%0d got=%0d want=%0d", s, r, c, k, od[s][k], e);
                chk($sformatf("data u%0d r%0d c%0d ch%0d", s, r, c, k), 64'(od[s][k]), 64'(e));
            end
        end
        chk($sformatf("mapdone u%0d r%0d c%0d", s, r, c), 64'(md[s]),
            64'(pos[s] == fw[s] * fw[s] - 1));
        chk($sformatf("err u%0d", s), 64'(er[s]), 64'(err_exp[s]));
        pos[s] = (pos[s] + 1) % (fw[s] * fw[s]);
    endtask

    task automatic glitch(input int s);
        v4[s] = 4'b0011;
        din[s][0] = int'($urandom);
        din[s][1] = int'($urandom);
        @(posedge clk); #1;
        v4[s] = 4'h0;
        err_exp[s] = 1'b1;
        $display("u%0d glitch iValid4=0011", s);
        chk_quiet(s);
    endtask

    task automatic check_reset_outputs();
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_valid u%0d", s), 64'(ov[s]), 64'd0);
            chk($sformatf("rst_done u%0d", s), 64'(md[s]), 64'd0);
            chk($sformatf("rst_err u%0d", s), 64'(er[s]), 64'd0);
            for (int k = 0; k < 4; k++)
                chk($sformatf("rst_data u%0d ch%0d", s, k), 64'(od[s][k]), 64'd0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        $display("reset asserted");
        check_reset_outputs();
        for (int s = 0; s < 2; s++) begin
            pos[s] = 0;
            err_exp[s] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
    endtask

    task automatic ramp_map(input int s, input bit gaps);
        for (int p = 0; p < fw[s] * fw[s]; p++)
            send(s, p + 1, p + 101, p + 201, p + 301, gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            v4[s] = 4'h0;
            for (int k = 0; k < 4; k++) din[s][k] = '0;
        end
        #2;
        do_reset();

        // Ramp maps, back to back, two maps.
        ramp_map(0, 1'b0);
        ramp_map(0, 1'b0);

        // All negative except channel 1 of pixel 6.
        for (int p = 0; p < 16; p++)
            send(0, -5, (p == 5) ? 7 : -5, -5, -5, 0);

        // Ramp with random gaps between beats.
        ramp_map(0, 1'b1);

        // 5x5 map: trailing row and column produce nothing.
        ramp_map(1, 1'b0);

        // Protocol glitch mid-map; results unaffected, error sticks.
        for (int p = 0; p < 16; p++) begin
            if (p == 7) glitch(0);
            send(0, p + 1, p + 101, p + 201, p + 301, 0);
        end
        ramp_map(0, 1'b0);

        // Reset after 9 beats, then a fresh map.
        for (int p = 0; p < 9; p++)
            send(0, int'($urandom), int'($urandom), int'($urandom), int'($urandom), 0);
        do_reset();
        ramp_map(0, 1'b0);

        // Random signed data on both sizes with random gaps.
        for (int m = 0; m < 3; m++) begin
            for (int s = 0; s < 2; s++) begin
                for (int p = 0; p < fw[s] * fw[s]; p++) begin
                    send(s,
                         int'($urandom_range(0, 2000)) - 1000,
                         int'($urandom),
                         int'($urandom_range(0, 20)) - 10,
                         int'($urandom),
                         int'($urandom_range(0, 2)));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
